// File: rtl/trap_pkg.sv
// trap_pkg: cause codes, CSR bit positions and FSM encoding for the trap sequencer.
package trap_pkg;
  localparam logic [4:0] CAUSE_INST_MISAL = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK     = 5'd3;
  localparam logic [4:0] CAUSE_LD_MISAL   = 5'd4;
  localparam logic [4:0] CAUSE_ST_MISAL   = 5'd6;
  localparam logic [4:0] CAUSE_ECALL      = 5'd11;
  localparam logic [4:0] IRQ_MSI          = 5'd3;
  localparam logic [4:0] IRQ_MTI          = 5'd7;
  localparam logic [4:0] IRQ_MEI          = 5'd11;
  localparam int MSI_BIT  = 3;
  localparam int MTI_BIT  = 7;
  localparam int MEI_BIT  = 11;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;
  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET, S_REDIR} state_t;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the highest-priority exception, else an enabled pending interrupt.
module trap_prio_enc import trap_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            wb_valid,
  input  logic            inst_misal,
  input  logic            illegal,
  input  logic            ebreak,
  input  logic            ecall,
  input  logic            ld_misal,
  input  logic            st_misal,
  input  logic            mret,
  input  logic            mie_en,
  input  logic [2:0]      irq,
  output logic            take,
  output logic            is_int,
  output logic [XLEN-1:0] cause
);
  logic exc, irq_ok;
  logic [4:0] ecode, icode;
  always_comb begin
    exc    = wb_valid & (inst_misal | illegal | ebreak | ecall | ld_misal | st_misal);
    irq_ok = wb_valid & mie_en & ~exc & ~mret & (|irq);
    ecode  = inst_misal ? CAUSE_INST_MISAL : illegal ? CAUSE_ILLEGAL : ebreak ? CAUSE_EBREAK :
             ecall ? CAUSE_ECALL : ld_misal ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
    // irq is {mei, mti, msi}; MSI outranks MTI
    icode  = irq[2] ? IRQ_MEI : irq[0] ? IRQ_MSI : IRQ_MTI;
    take   = exc | irq_ok;
    is_int = irq_ok;
    cause  = exc ? {{(XLEN-5){1'b0}}, ecode} : {1'b1, {(XLEN-6){1'b0}}, icode};
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer driving CSR exception writes, flush and redirect.
module trap_ctrl import trap_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_valid_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic [XLEN-1:0] wb_next_pc_i,
  input  logic [XLEN-1:0] wb_inst_i,
  input  logic [XLEN-1:0] wb_addr_i,
  input  logic            e_inst_misal_i,
  input  logic            e_illegal_i,
  input  logic            e_ebreak_i,
  input  logic            e_ecall_i,
  input  logic            e_ld_misal_i,
  input  logic            e_st_misal_i,
  input  logic            mret_i,
  input  logic            meip_i,
  input  logic            mtip_i,
  input  logic            msip_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  output logic            we_exc_o,
  output logic            is_int_o,
  output logic [XLEN-1:0] mcause_d_o,
  output logic [XLEN-1:0] mepc_d_o,
  output logic [XLEN-1:0] mtval_d_o,
  output logic [XLEN-1:0] mstatus_d_o,
  output logic [XLEN-1:0] mip_d_o,
  output logic            sel_exc_nret_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o
);
  state_t st;
  logic take, is_int, ret, stall_q;
  logic [2:0] irq;
  logic [XLEN-1:0] cause, pend, mtval_c, mst_trap, mst_ret;
  assign irq = {meip_i & mie_i[MEI_BIT], mtip_i & mie_i[MTI_BIT], msip_i & mie_i[MSI_BIT]};
  trap_prio_enc #(.XLEN(XLEN)) u_enc (
    .wb_valid   (wb_valid_i),
    .inst_misal (e_inst_misal_i),
    .illegal    (e_illegal_i),
    .ebreak     (e_ebreak_i),
    .ecall      (e_ecall_i),
    .ld_misal   (e_ld_misal_i),
    .st_misal   (e_st_misal_i),
    .mret       (mret_i),
    .mie_en     (mstatus_i[MIE_BIT]),
    .irq        (irq),
    .take       (take),
    .is_int     (is_int),
    .cause      (cause)
  );
  // an interrupt can never coexist with mret, so any take means an exception beat mret
  assign ret = wb_valid_i & mret_i & ~take;
  assign stall_o = stall_q | ((st == S_IDLE) & (take | ret));
  always_comb begin
    pend = '0;
    pend[MEI_BIT] = meip_i;
    pend[MTI_BIT] = mtip_i;
    pend[MSI_BIT] = msip_i;
    mtval_c = is_int ? '0 :
              (cause[4:0] == CAUSE_INST_MISAL || cause[4:0] == CAUSE_LD_MISAL ||
               cause[4:0] == CAUSE_ST_MISAL) ? wb_addr_i :
              (cause[4:0] == CAUSE_ILLEGAL) ? wb_inst_i : '0;
    mst_trap = mstatus_i;
    mst_trap[MPIE_BIT] = mstatus_i[MIE_BIT];
    mst_trap[MIE_BIT] = 1'b0;
    mst_trap[MPP_HI:MPP_LO] = 2'b11;
    mst_ret = mstatus_i;
    mst_ret[MIE_BIT] = mstatus_i[MPIE_BIT];
    mst_ret[MPIE_BIT] = 1'b1;
    mst_ret[MPP_HI:MPP_LO] = 2'b11;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st             <= S_IDLE;
      stall_q        <= 1'b0;
      we_exc_o       <= 1'b0;
      is_int_o       <= 1'b0;
      flush_o        <= 1'b0;
      redirect_o     <= 1'b0;
      sel_exc_nret_o <= 1'b0;
      mcause_d_o     <= '0;
      mepc_d_o       <= '0;
      mtval_d_o      <= '0;
      mstatus_d_o    <= '0;
      mip_d_o        <= '0;
    end else begin
      mip_d_o    <= pend;
      we_exc_o   <= 1'b0;
      is_int_o   <= 1'b0;
      flush_o    <= 1'b0;
      redirect_o <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (take) begin
            st             <= S_TRAP;
            stall_q        <= 1'b1;
            we_exc_o       <= 1'b1;
            flush_o        <= 1'b1;
            is_int_o       <= is_int;
            sel_exc_nret_o <= 1'b0;
            mcause_d_o     <= cause;
            mepc_d_o       <= is_int ? wb_next_pc_i : wb_pc_i;
            mtval_d_o      <= mtval_c;
            mstatus_d_o    <= mst_trap;
          end else if (ret) begin
            st             <= S_RET;
            stall_q        <= 1'b1;
            we_exc_o       <= 1'b1;
            flush_o        <= 1'b1;
            sel_exc_nret_o <= 1'b1;
            mstatus_d_o    <= mst_ret;
          end
        end
        S_TRAP, S_RET: begin
          st         <= S_REDIR;
          redirect_o <= 1'b1;
        end
        default: begin
          st             <= S_IDLE;
          stall_q        <= 1'b0;
          sel_exc_nret_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven scoreboard bench for trap_ctrl plus multi-cycle corner sequences.
module tb_trap_ctrl;
  typedef struct {
    logic        valid;
    logic [5:0]  exc;
    logic        mret;
    logic [2:0]  irq;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        ev;
    logic        is_ret;
    logic        is_int;
    logic [31:0] cause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] mst;
  } vec_t;
  logic clk = 0, rst_i = 0;
  logic wb_valid_i = 0, mret_i = 0, meip_i = 0, mtip_i = 0, msip_i = 0;
  logic e_inst_misal_i = 0, e_illegal_i = 0, e_ebreak_i = 0, e_ecall_i = 0, e_ld_misal_i = 0, e_st_misal_i = 0;
  logic [31:0] wb_pc_i = 0, wb_next_pc_i = 0, wb_inst_i = 0, wb_addr_i = 0, mstatus_i = 0, mie_i = 0;
  logic we_exc_o, is_int_o, sel_exc_nret_o, stall_o, flush_o, redirect_o;
  logic [31:0] mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o;
  int n_cmp = 0, n_err = 0;
  vec_t tbl[17];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  trap_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_next_pc_i(wb_next_pc_i), .wb_inst_i(wb_inst_i), .wb_addr_i(wb_addr_i),
    .e_inst_misal_i(e_inst_misal_i), .e_illegal_i(e_illegal_i), .e_ebreak_i(e_ebreak_i),
    .e_ecall_i(e_ecall_i), .e_ld_misal_i(e_ld_misal_i), .e_st_misal_i(e_st_misal_i),
    .mret_i(mret_i), .meip_i(meip_i), .mtip_i(mtip_i), .msip_i(msip_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .we_exc_o(we_exc_o), .is_int_o(is_int_o),
    .mcause_d_o(mcause_d_o), .mepc_d_o(mepc_d_o), .mtval_d_o(mtval_d_o),
    .mstatus_d_o(mstatus_d_o), .mip_d_o(mip_d_o), .sel_exc_nret_o(sel_exc_nret_o),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    wb_valid_i = v.valid;
    {e_inst_misal_i, e_illegal_i, e_ebreak_i, e_ecall_i, e_ld_misal_i, e_st_misal_i} = v.exc;
    mret_i = v.mret;
    {meip_i, mtip_i, msip_i} = v.irq;
    mstatus_i = v.mstatus;
    mie_i = v.mie;
    wb_pc_i = v.pc;
    wb_next_pc_i = v.npc;
    wb_inst_i = v.inst;
    wb_addr_i = v.addr;
  endtask
  task automatic quiet();
    wb_valid_i = 0;
    {e_inst_misal_i, e_illegal_i, e_ebreak_i, e_ecall_i, e_ld_misal_i, e_st_misal_i} = '0;
    mret_i = 0;
    {meip_i, mtip_i, msip_i} = '0;
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    logic [31:0] mip_exp;
    mip_exp = ({31'd0, v.irq[2]} << 11) | ({31'd0, v.irq[1]} << 7) | ({31'd0, v.irq[0]} << 3);
    @(negedge clk);
    drive(v);
    #1 chk($sformatf("v%0d stall_n", idx), {31'd0, stall_o}, {31'd0, v.ev});
    @(posedge clk);
    if (v.ev) exp_q.push_back(v);
    @(negedge clk);
    quiet();
    #1;
    chk($sformatf("v%0d we_exc", idx), {31'd0, we_exc_o}, {31'd0, v.ev});
    chk($sformatf("v%0d flush", idx), {31'd0, flush_o}, {31'd0, v.ev});
    chk($sformatf("v%0d mip", idx), mip_d_o, mip_exp);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d is_int", idx), {31'd0, is_int_o}, {31'd0, e.is_int});
      chk($sformatf("v%0d sel_n1", idx), {31'd0, sel_exc_nret_o}, {31'd0, e.is_ret});
      chk($sformatf("v%0d mcause", idx), mcause_d_o, e.cause);
      chk($sformatf("v%0d mepc", idx), mepc_d_o, e.mepc);
      chk($sformatf("v%0d mtval", idx), mtval_d_o, e.mtval);
      chk($sformatf("v%0d mstatus", idx), mstatus_d_o, e.mst);
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d redirect", idx), {31'd0, redirect_o}, {31'd0, v.ev});
    chk($sformatf("v%0d sel_n2", idx), {31'd0, sel_exc_nret_o}, {31'd0, v.ev & v.is_ret});
    chk($sformatf("v%0d we_exc_n2", idx), {31'd0, we_exc_o}, 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d idle_redirect", idx), {31'd0, redirect_o}, 32'd0);
    chk($sformatf("v%0d idle_stall", idx), {31'd0, stall_o}, 32'd0);
  endtask
  initial begin
    // exc bits: {inst_misal, illegal, ebreak, ecall, ld_misal, st_misal}; irq bits: {meip, mtip, msip}
    tbl[0]  = '{1, 6'b010000, 0, 3'b000, 32'h8, 0, 32'h100, 32'h104, 32'hFFFFFFFF, 0, 1, 0, 0, 32'd2, 32'h100, 32'hFFFFFFFF, 32'h1880};
    tbl[1]  = '{1, 6'b000100, 0, 3'b100, 32'h8, 32'h800, 32'h200, 32'h204, 32'h73, 0, 1, 0, 0, 32'd11, 32'h200, 0, 32'h1880};
    tbl[2]  = '{1, 6'b000000, 0, 3'b011, 32'h8, 32'h88, 32'h200, 32'h204, 0, 0, 1, 0, 1, 32'h80000003, 32'h204, 0, 32'h1880};
    tbl[3]  = '{1, 6'b000000, 1, 3'b000, 32'h80, 0, 32'h250, 32'h254, 0, 0, 1, 1, 0, 32'h80000003, 32'h204, 0, 32'h1888};
    tbl[4]  = '{1, 6'b110010, 0, 3'b000, 32'h0, 0, 32'h300, 32'h304, 32'hDEAD, 32'h33, 1, 0, 0, 32'd0, 32'h300, 32'h33, 32'h1800};
    tbl[5]  = '{1, 6'b000010, 0, 3'b000, 32'h1888, 0, 32'h304, 32'h308, 0, 32'h44, 1, 0, 0, 32'd4, 32'h304, 32'h44, 32'h1880};
    tbl[6]  = '{1, 6'b000001, 0, 3'b000, 32'h0, 0, 32'h308, 32'h30C, 0, 32'h55, 1, 0, 0, 32'd6, 32'h308, 32'h55, 32'h1800};
    tbl[7]  = '{1, 6'b001000, 0, 3'b000, 32'h8, 0, 32'h400, 32'h404, 32'h00100073, 32'h9, 1, 0, 0, 32'd3, 32'h400, 0, 32'h1880};
    tbl[8]  = '{1, 6'b010000, 1, 3'b000, 32'h80, 0, 32'h500, 32'h504, 32'h12345678, 0, 1, 0, 0, 32'd2, 32'h500, 32'h12345678, 32'h1800};
    tbl[9]  = '{1, 6'b000000, 0, 3'b111, 32'h8, 32'h888, 32'h600, 32'h604, 0, 0, 1, 0, 1, 32'h8000000B, 32'h604, 0, 32'h1880};
    tbl[10] = '{1, 6'b000000, 0, 3'b011, 32'h8, 32'h888, 32'h700, 32'h704, 0, 0, 1, 0, 1, 32'h80000003, 32'h704, 0, 32'h1880};
    tbl[11] = '{1, 6'b000000, 0, 3'b010, 32'h8, 32'h80, 32'h740, 32'h744, 0, 0, 1, 0, 1, 32'h80000007, 32'h744, 0, 32'h1880};
    tbl[12] = '{1, 6'b000000, 0, 3'b100, 32'h0, 32'h800, 32'h780, 32'h784, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 6'b010000, 0, 3'b100, 32'h8, 32'h800, 32'h790, 32'h794, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 6'b000000, 0, 3'b100, 32'h8, 32'h0, 32'h7A0, 32'h7A4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 6'b000000, 1, 3'b100, 32'h88, 32'h800, 32'h7B0, 32'h7B4, 0, 0, 1, 1, 0, 32'h80000007, 32'h744, 0, 32'h1888};
    tbl[16] = '{1, 6'b000100, 0, 3'b000, 32'hFFFFFFFF, 0, 32'h800, 32'h804, 0, 0, 1, 0, 0, 32'd11, 32'h800, 0, 32'hFFFFFFF7};
    #12;
    chk("rst we_exc", {31'd0, we_exc_o}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst mcause", mcause_d_o, 32'd0);
    chk("rst mstatus", mstatus_d_o, 32'd0);
    @(negedge clk);
    rst_i = 1;
    for (int i = 0; i < 17; i++) run_vec(i, tbl[i]);
    // MEIP pending while MIE=0: ten retiring instructions, no trap
    @(negedge clk);
    wb_valid_i = 1; meip_i = 1; mie_i = 32'h800; mstatus_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("masked%0d we_exc", i), {31'd0, we_exc_o}, 32'd0);
      chk($sformatf("masked%0d stall", i), {31'd0, stall_o}, 32'd0);
    end
    mstatus_i = 32'h8;
    #1 chk("unmask stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    quiet();
    #1;
    chk("unmask we_exc", {31'd0, we_exc_o}, 32'd1);
    chk("unmask is_int", {31'd0, is_int_o}, 32'd1);
    chk("unmask mcause", mcause_d_o, 32'h8000000B);
    repeat (3) @(negedge clk);
    // reset asserted while in TRAP
    wb_valid_i = 1; e_illegal_i = 1; wb_pc_i = 32'h900; wb_inst_i = 32'hABCD;
    @(negedge clk);
    quiet();
    #1 chk("pre-rst we_exc", {31'd0, we_exc_o}, 32'd1);
    rst_i = 0;
    #1;
    chk("midrst we_exc", {31'd0, we_exc_o}, 32'd0);
    chk("midrst flush", {31'd0, flush_o}, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    chk("midrst mepc", mepc_d_o, 32'd0);
    chk("midrst mtval", mtval_d_o, 32'd0);
    @(negedge clk);
    rst_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d redirect", i), {31'd0, redirect_o}, 32'd0);
      chk($sformatf("postrst%0d we_exc", i), {31'd0, we_exc_o}, 32'd0);
    end
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
